sweep_tone_generator: RTL

SWEEP_TONE_GENERATOR -- requirements
Module: sweep_tone_generator

---
 rtl/sweep_pkg.sv | 51 +++++
 rtl/sine_quarter_lut.sv | 54 +++++
 rtl/sweep_tone_generator.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/sweep_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sweep_pkg
//  Description : Shared encodings for the sweep tone generator: sweep modes,
//                FSM states, peak amplitude and quarter-wave table contents.
//  Revision    : 1.0 - initial release
// ============================================================================
package sweep_pkg;

    // Sweep mode encodings (2'b11 falls through to one-shot behaviour)
    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_REPEAT   = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;

    // Controller state encodings
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Peak table amplitude; one below full scale so negation cannot overflow
    function automatic longint max_amp(input int data_width);
        return (longint'(1) <<< (data_width - 1)) - longint'(1);
    endfunction

    // sin() over [0, pi/2]; the last table index maps exactly to pi/2 so the
    // quadrant boundaries land on 0 and +/-MAX
    function automatic real quarter_sin(input int idx, input int addr_width);
        real x;
        real term;
        real sum;
        x    = 1.5707963267948966 * real'(idx) / real'((1 << addr_width) - 1);
        term = x;
        sum  = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

    // Rounded, clamped table entry for index idx
    function automatic longint lut_entry(input int idx, input int addr_width,
                                         input int data_width);
        longint r;
        r = longint'($rtoi(quarter_sin(idx, addr_width) * real'(max_amp(data_width)) + 0.5));
        if (r > max_amp(data_width)) r = max_amp(data_width);
        if (r < 0) r = 0;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sine_quarter_lut.sv
`default_nettype none
// ============================================================================
//  Module      : sine_quarter_lut
//  Description : Phase-to-sample conversion from a quarter-wave table with
//                quadrant mirroring and negation; one registered stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module sine_quarter_lut
    import sweep_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int LUT_ADDR_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_en,
    input  logic [LUT_ADDR_WIDTH+1:0]     i_phase,
    output logic signed [DATA_WIDTH-1:0]  o_sample
);

    localparam int c_depth = 1 << LUT_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]     w_rom [c_depth];
    logic [1:0]                w_quad;
    logic [LUT_ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0]     w_mag;
    logic [DATA_WIDTH-1:0]     w_val;

    // Table contents are elaboration-time constants
    generate
        for (genvar k = 0; k < c_depth; k++) begin : g_rom
            localparam logic [DATA_WIDTH-1:0] c_val =
                DATA_WIDTH'(lut_entry(k, LUT_ADDR_WIDTH, DATA_WIDTH));
            assign w_rom[k] = c_val;
        end
    endgenerate

    // Quadrants 1/3 read the table backwards, quadrants 2/3 negate
    assign w_quad = i_phase[LUT_ADDR_WIDTH+1:LUT_ADDR_WIDTH];
    assign w_addr = w_quad[0] ? ~i_phase[LUT_ADDR_WIDTH-1:0] : i_phase[LUT_ADDR_WIDTH-1:0];
    assign w_mag  = w_rom[w_addr];
    assign w_val  = w_quad[1] ? (~w_mag + DATA_WIDTH'(1)) : w_mag;

    // Output register, only updated for qualified phases
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_sample <= '0;
        end else if (i_en) begin
            o_sample <= w_val;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sweep_tone_generator.sv
`default_nettype none
// ============================================================================
//  Module      : sweep_tone_generator
//  Description : Stepped-frequency sine generator. Walks a list of FCWs in
//                one-shot, repeat or ping-pong order, dwelling a programmable
//                number of samples at each point, with continuous phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module sweep_tone_generator
    import sweep_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int PHASE_WIDTH    = 32,
    parameter int LUT_ADDR_WIDTH = 8,
    parameter int STEP_WIDTH     = 8,
    parameter int DWELL_WIDTH    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [1:0]                    mode,
    input  logic [PHASE_WIDTH-1:0]        start_fcw,
    input  logic [PHASE_WIDTH-1:0]        step_fcw,
    input  logic [STEP_WIDTH-1:0]         num_steps,
    input  logic [DWELL_WIDTH-1:0]        dwell,
    output logic signed [DATA_WIDTH-1:0]  sine_out,
    output logic                          sine_valid,
    output logic [PHASE_WIDTH-1:0]        cur_fcw,
    output logic [STEP_WIDTH-1:0]         step_idx,
    output logic                          busy,
    output logic                          done
);

    // Sweep configuration captured at start
    logic [0:0]              r_state;
    logic [1:0]              r_mode;
    logic [PHASE_WIDTH-1:0]  r_start_fcw;
    logic [PHASE_WIDTH-1:0]  r_step_fcw;
    logic [STEP_WIDTH-1:0]   r_last_pt;
    logic [DWELL_WIDTH-1:0]  r_dwell_last;
    // Running sweep position
    logic [PHASE_WIDTH-1:0]  r_phase;
    logic [PHASE_WIDTH-1:0]  r_fcw;
    logic [STEP_WIDTH-1:0]   r_pt;
    logic [DWELL_WIDTH-1:0]  r_dwell_cnt;
    logic                    r_dir;
    // Pipeline stage 1 (feeds the table) and stage 2 (aligned with sine_out)
    logic                      r_s1_valid;
    logic                      r_s1_last;
    logic [LUT_ADDR_WIDTH+1:0] r_s1_phase;
    logic [PHASE_WIDTH-1:0]    r_s1_fcw;
    logic [STEP_WIDTH-1:0]     r_s1_idx;
    logic                      r_s2_valid;
    logic                      r_s2_last;
    logic [PHASE_WIDTH-1:0]    r_s2_fcw;
    logic [STEP_WIDTH-1:0]     r_s2_idx;

    logic                    w_busy;
    logic                    w_dwell_end;
    logic                    w_at_last;
    logic                    w_final;
    logic [STEP_WIDTH-1:0]   w_next_pt;
    logic [PHASE_WIDTH-1:0]  w_next_fcw;
    logic                    w_next_dir;

    assign w_busy      = (r_state == ST_RUN) | r_s1_valid | r_s2_valid;
    assign w_dwell_end = (r_dwell_cnt == r_dwell_last);
    assign w_at_last   = (r_pt == r_last_pt);

    // Next point selection at the end of each dwell
    always_comb begin
        w_next_pt  = r_pt;
        w_next_fcw = r_fcw;
        w_next_dir = r_dir;
        w_final    = 1'b0;
        if (w_dwell_end) begin
            case (r_mode)
                MODE_REPEAT: begin
                    if (w_at_last) begin
                        w_next_pt  = '0;
                        w_next_fcw = r_start_fcw;
                    end else begin
                        w_next_pt  = r_pt + STEP_WIDTH'(1);
                        w_next_fcw = r_fcw + r_step_fcw;
                    end
                end
                MODE_PINGPONG: begin
                    // A single-point sweep simply holds point 0
                    if (r_last_pt != '0) begin
                        if ((!r_dir && !w_at_last) || (r_dir && r_pt == '0)) begin
                            w_next_dir = 1'b0;
                            w_next_pt  = r_pt + STEP_WIDTH'(1);
                            w_next_fcw = r_fcw + r_step_fcw;
                        end else begin
                            w_next_dir = 1'b1;
                            w_next_pt  = r_pt - STEP_WIDTH'(1);
                            w_next_fcw = r_fcw - r_step_fcw;
                        end
                    end
                end
                default: begin
                    if (w_at_last) begin
                        w_final = 1'b1;
                    end else begin
                        w_next_pt  = r_pt + STEP_WIDTH'(1);
                        w_next_fcw = r_fcw + r_step_fcw;
                    end
                end
            endcase
        end
    end

    // Controller: accept start when drained, then issue one phase per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_mode       <= MODE_ONESHOT;
            r_start_fcw  <= '0;
            r_step_fcw   <= '0;
            r_last_pt    <= '0;
            r_dwell_last <= '0;
            r_phase      <= '0;
            r_fcw        <= '0;
            r_pt         <= '0;
            r_dwell_cnt  <= '0;
            r_dir        <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s1_last    <= 1'b0;
            r_s1_phase   <= '0;
            r_s1_fcw     <= '0;
            r_s1_idx     <= '0;
        end else if (abort) begin
            r_state    <= ST_IDLE;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
        end else begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    r_s1_valid  <= 1'b1;
                    r_s1_last   <= w_final;
                    r_s1_phase  <= r_phase[PHASE_WIDTH-1 -: LUT_ADDR_WIDTH+2];
                    r_s1_fcw    <= r_fcw;
                    r_s1_idx    <= r_pt;
                    r_phase     <= r_phase + r_fcw;
                    r_dwell_cnt <= w_dwell_end ? '0 : r_dwell_cnt + DWELL_WIDTH'(1);
                    r_pt        <= w_next_pt;
                    r_fcw       <= w_next_fcw;
                    r_dir       <= w_next_dir;
                    if (w_final) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    if (start && !w_busy) begin
                        r_state      <= ST_RUN;
                        r_mode       <= mode;
                        r_start_fcw  <= start_fcw;
                        r_step_fcw   <= step_fcw;
                        r_last_pt    <= (num_steps == '0) ? '0 : num_steps - STEP_WIDTH'(1);
                        r_dwell_last <= (dwell == '0) ? '0 : dwell - DWELL_WIDTH'(1);
                        r_phase      <= '0;
                        r_fcw        <= start_fcw;
                        r_pt         <= '0;
                        r_dwell_cnt  <= '0;
                        r_dir        <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Stage 2 sideband, kept in step with the table output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_fcw   <= '0;
            r_s2_idx   <= '0;
        end else if (abort) begin
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
            if (r_s1_valid) begin
                r_s2_fcw <= r_s1_fcw;
                r_s2_idx <= r_s1_idx;
            end
        end
    end

    sine_quarter_lut #(
        .DATA_WIDTH     (DATA_WIDTH),
        .LUT_ADDR_WIDTH (LUT_ADDR_WIDTH)
    ) u_lut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (r_s1_valid),
        .i_phase  (r_s1_phase),
        .o_sample (sine_out)
    );

    assign sine_valid = r_s2_valid;
    assign cur_fcw    = r_s2_fcw;
    assign step_idx   = r_s2_idx;
    assign busy       = w_busy;
    assign done       = r_s2_valid & r_s2_last;

endmodule
`default_nettype wire
